// File: rtl/udcnt_pkg.sv
// Shared types and next-count arithmetic for the up/down counter.
package udcnt_pkg;

  // Arithmetic width: supports counters up to 32 bits plus one overflow bit.
  localparam int unsigned CALC_W = 33;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  typedef struct packed {
    logic [CALC_W-1:0] val;
    logic              carry;
  } step_res_t;

  // One step in the given direction, saturating or wrapping at 0 / max_val.
  function automatic step_res_t next_count(
    input logic [CALC_W-1:0] cnt,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] max_val,
    input dir_e              dir,
    input logic              wrap_en
  );
    step_res_t r;
    r = '0;
    if (dir == DIR_UP) begin
      if (cnt + step <= max_val) begin
        r.val = cnt + step;
      end else if (wrap_en) begin
        r.val   = cnt + step - (max_val + CALC_W'(1));
        r.carry = 1'b1;
      end else begin
        r.val = max_val;
      end
    end else begin
      if (cnt >= step) begin
        r.val = cnt - step;
      end else if (wrap_en) begin
        r.val   = cnt + (max_val + CALC_W'(1)) - step;
        r.carry = 1'b1;
      end else begin
        r.val = '0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/udcnt_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clk cycles.
// The first tick is high during the DIV-th cycle after reset release.
module udcnt_tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Divider count and registered tick, asserted while r_cnt sits at DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_PRE);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/updown_counter_ar.sv
// Up/down counter with hold-to-repeat, programmable limit, step and
// saturate/wrap overflow. Optional feature macro: UDCNT_WRAP_EN enables the
// wrap input and the carry pulse; without it the counter always saturates.
module updown_counter_ar
  import udcnt_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_VAL    = (2**WIDTH) - 1,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned REPEAT_DLY = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             wrap,
  output logic [WIDTH-1:0] c_out,
  output logic             z,
  output logic             m,
  output logic             carry
);

  localparam int unsigned RPT_W = $clog2(REPEAT_DLY + 1);
  localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [CALC_W-1:0] MAX_C    = CALC_W'(MAX_VAL);
  localparam logic [CALC_W-1:0] STEP_C   = CALC_W'(STEP);

  logic             w_tick;
  logic             w_valid;
  dir_e             w_req_dir;
  logic             w_wrap_en;
  logic             w_step;
  state_e           r_state, w_state_nxt;
  dir_e             r_dir, w_dir_nxt;
  logic [RPT_W-1:0] r_rpt, w_rpt_nxt;
  logic [RPT_W-1:0] w_rpt_inc;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_ld_sat;
  step_res_t        w_res;
  logic             w_unused_hi;

  udcnt_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign w_valid   = u ^ d;
  assign w_req_dir = u ? DIR_UP : DIR_DN;
  assign w_rpt_inc = r_rpt + RPT_W'(1);

`ifdef UDCNT_WRAP_EN
  assign w_wrap_en = wrap;
`else
  logic w_unused_wrap;
  assign w_wrap_en     = 1'b0;
  assign w_unused_wrap = wrap;
`endif

  // FSM state, latched direction and repeat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dir   <= DIR_UP;
      r_rpt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_rpt   <= w_rpt_nxt;
    end
  end

  // Next-state and step decision; clr/ld abort any hold/repeat sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_rpt_nxt   = r_rpt;
    w_step      = 1'b0;
    if (clr || ld) begin
      w_state_nxt = IDLE;
      w_rpt_nxt   = '0;
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            w_step      = 1'b1;
            w_dir_nxt   = w_req_dir;
            w_rpt_nxt   = '0;
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (w_valid && (w_req_dir == r_dir)) begin
            w_rpt_nxt = w_rpt_inc;
            if (w_rpt_inc >= RPT_LAST) begin
              w_step      = 1'b1;
              w_state_nxt = REPEAT;
            end
          end else begin
            w_state_nxt = IDLE;
            w_rpt_nxt   = '0;
          end
        end
        REPEAT: begin
          if (w_valid && (w_req_dir == r_dir)) begin
            w_step = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_rpt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rpt_nxt   = '0;
        end
      endcase
    end
  end

  // Step result and clamped load value.
  always_comb begin
    w_res    = next_count(CALC_W'(r_cnt), STEP_C, MAX_C, w_dir_nxt, w_wrap_en);
    w_ld_sat = (CALC_W'(ld_val) > MAX_C) ? WIDTH'(MAX_C) : ld_val;
  end

  assign w_unused_hi = ^w_res.val[CALC_W-1:WIDTH];

  // Count register: clr beats ld beats a tick step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (ld) begin
      r_cnt <= w_ld_sat;
    end else if (w_step) begin
      r_cnt <= WIDTH'(w_res.val);
    end
  end

`ifdef UDCNT_WRAP_EN
  logic r_carry;

  // Carry pulse for the single cycle after a wrapping step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_step && !clr && !ld && w_res.carry;
    end
  end

  assign carry = r_carry;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_res.carry;
  assign carry          = 1'b0;
`endif

  assign c_out = r_cnt;
  assign z     = (r_cnt == '0);
  assign m     = (r_cnt == WIDTH'(MAX_VAL));

endmodule
